// File: rtl/store_aligner_pkg.sv
// Shared types for the store aligner: access sizes, FSM states and the
// per-size byte-enable base pattern.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FIRST  = 2'b01,
        SECOND = 2'b10
    } state_e;

    localparam int NUM_LANES = 4;

    // Byte-enable pattern for a store at lane 0; an illegal size enables nothing.
    function automatic logic [NUM_LANES-1:0] size_mask(input size_e sz);
        logic [NUM_LANES-1:0] m;
        case (sz)
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_aligner_lane_shifter.sv
// Combinational lane placement: narrows store data to its size and shifts data and
// byte enables across an 8-lane window so word-crossing stores show up in the top half.
module lane_shifter
    import store_pkg::*;
(
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic [31:0] data_i,
    output logic [7:0]  mask8_o,
    output logic [63:0] data64_o,
    output logic        crossing_o
);

    logic [NUM_LANES-1:0] base;
    logic [31:0]          data_mask;

    assign base = size_mask(size_i);

    // Zero the bytes above the access size so unused lanes always carry 0.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_mask
        assign data_mask[8*gi +: 8] = {8{base[gi]}};
    end

    assign mask8_o    = {4'b0000, base} << off_i;
    assign data64_o   = {32'h0, data_i & data_mask} << {off_i, 3'b000};
    assign crossing_o = |mask8_o[7:4];

endmodule

// File: rtl/store_aligner.sv
// Store aligner: accepts byte/half/word stores, issues lane-positioned word writes
// to data memory and splits word-crossing stores into two back-to-back accesses.
module store_aligner
    import store_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be
);

    state_e            state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] hi_addr_q;
    logic [DATA_W-1:0] hi_wdata_q;
    logic [3:0]        hi_be_q;
    logic              cross_q;
    logic              done_q;
    logic              err_q;

    size_e             size_d;
    logic [7:0]        mask8_d;
    logic [63:0]       data64_d;
    logic              crossing_d;
    logic [ADDR_W-1:0] lo_addr_d;
    logic              accept_d;
    logic              reject_d;

    assign size_d    = size_e'(st_size);
    assign lo_addr_d = {st_addr[ADDR_W-1:2], 2'b00};
    assign accept_d  = st_valid && (state_q == IDLE);
    assign reject_d  = (size_d == SZ_ILL) || (crossing_d && !SPLIT_EN);

    lane_shifter u_lane_shifter (
        .off_i      (st_addr[1:0]),
        .size_i     (size_d),
        .data_i     (st_data),
        .mask8_o    (mask8_d),
        .data64_o   (data64_d),
        .crossing_o (crossing_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            hi_addr_q   <= '0;
            hi_wdata_q  <= '0;
            hi_be_q     <= '0;
            cross_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        if (reject_d) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= FIRST;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= lo_addr_d;
                            mem_be_q    <= mask8_d[3:0];
                            mem_wdata_q <= data64_d[31:0];
                            // Upper half waits here; the +4 wraps naturally at ADDR_W bits.
                            hi_addr_q   <= lo_addr_d + ADDR_W'(4);
                            hi_be_q     <= mask8_d[7:4];
                            hi_wdata_q  <= data64_d[63:32];
                            cross_q     <= crossing_d;
                        end
                    end
                end
                FIRST: begin
                    if (mem_gnt) begin
                        if (cross_q) begin
                            state_q     <= SECOND;
                            mem_addr_q  <= hi_addr_q;
                            mem_be_q    <= hi_be_q;
                            mem_wdata_q <= hi_wdata_q;
                        end else begin
                            state_q     <= IDLE;
                            mem_req_q   <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_be_q    <= '0;
                            mem_wdata_q <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                SECOND: begin
                    if (mem_gnt) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign st_ready  = (state_q == IDLE);
    assign st_done   = done_q;
    assign st_err    = err_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
- Write-side counterpart of the decode/load sign-extension path: narrows byte/half/word store data and places it on the correct byte lanes of a 32-bit word-addressed data memory.
- Sits between execute/LSU issue and the data-memory port.
- Drives a valid/grant request handshake.
- A store that crosses a word boundary is split into two sequential word accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; only 32 is supported (4 byte lanes).
- SPLIT_EN, 1, 1 = split word-crossing stores into two accesses; 0 = flag them as errors with no access.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- st_valid  in  1  store request from execute.
- st_ready  out  1  aligner can accept a request.
- st_addr  in  ADDR_W  byte address.
- st_data  in  DATA_W  store data, right-justified.
- st_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- st_done  out  1  one-cycle pulse: store fully granted.
- st_err  out  1  one-cycle pulse: illegal size, or crossing store with SPLIT_EN = 0.
- mem_req  out  1  memory request valid.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  DATA_W  lane-positioned write data.
- mem_be  out  4  byte enables.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; st_ready = 1; mem_req, st_done, st_err = 0; mem_addr, mem_wdata, mem_be = 0.
- States: IDLE, FIRST, SECOND.
- st_ready = 1 only in IDLE.
- Acceptance: st_valid && st_ready on a rising edge. On acceptance:
  - off = st_addr[1:0].
  - mask8 = {4'b0, base} << off, with base = 0001 / 0011 / 1111 for byte / half / word.
  - data64 = {32'b0, st_data masked to size} << 8*off.
  - crossing = |mask8[7:4].
- Illegal size, or crossing with SPLIT_EN = 0: st_err pulses in the next cycle, no memory access, state stays IDLE.
- Otherwise, registered outputs in the next cycle (request latency 1):
  - state FIRST, mem_req = 1.
  - mem_addr = {st_addr[ADDR_W-1:2], 2'b00}.
  - mem_be = mask8[3:0], mem_wdata = data64[31:0].
- Upper half is captured in internal registers for SECOND:
  - addr = mem_addr + 4, be = mask8[7:4], wdata = data64[63:32].
- Lanes not enabled carry 0 in mem_wdata.
- FIRST: mem_req and all mem_* outputs are held stable until mem_gnt.
  - On grant with crossing: next cycle state SECOND, mem_* loaded with the upper-half registers, mem_req stays 1 (no bubble).
  - On grant without crossing: next cycle state IDLE, mem_req = 0, st_done = 1 for one cycle.
- SECOND: outputs held until mem_gnt; then state IDLE, mem_req = 0, st_done pulse.
- Address wrap: the SECOND address wraps modulo 2^ADDR_W (0xFFFF_FFFC + 4 -> 0).
- mem_gnt while mem_req = 0 is ignored.
- A new store can be accepted in the cycle st_done is high, since state is already IDLE.
- Reset mid-operation drops mem_req immediately, abandons the transaction, and produces no st_done.
- st_done and st_err are never high together.

Decomposition:
- Package store_pkg:
  - typedef enum logic [1:0] size_e {SZ_B, SZ_H, SZ_W, SZ_ILL}.
  - typedef enum state_e {IDLE, FIRST, SECOND}.
  - localparam NUM_LANES = 4.
  - function size_mask(size_e) -> 4-bit base mask.
- One combinational sub-module, lane_shifter: inputs off, size, data; outputs mask8, data64, crossing.
- FSM and registers stay in store_aligner.

Test Plan:
- Byte store, addr 0x1003, data 0xDEADBEEF, gnt held 1 -> 1 cycle later mem_req = 1, mem_addr 0x1000, be 1000, wdata 0xEF000000; st_done 2 cycles after acceptance.
- Half store, addr 0x2001, data 0x0000ABCD, gnt delayed 3 cycles -> be 0110, wdata 0x00ABCD00, outputs stable while waiting, single access, one st_done.
- Word store, addr 0x3002, data 0x11223344, SPLIT_EN = 1 ->
  - FIRST: addr 0x3000, be 1100, wdata 0x33440000.
  - SECOND: addr 0x3004, be 0011, wdata 0x00001122.
  - Back-to-back, exactly one st_done.
- Same stimulus with SPLIT_EN = 0, plus a separate store with st_size = 11 -> st_err pulse each time, mem_req never asserted, st_ready stays 1.
- Word store at 0xFFFFFFFF -> FIRST addr 0xFFFFFFFC, be 1000; SECOND addr 0x00000000, be 0111.
- Assert rst while in SECOND awaiting gnt -> mem_req = 0 in the same cycle (asynchronous), no st_done, st_ready = 1; a store issued after reset completes normally.
